// File: rtl/rv32e_mem_arbiter_if.sv
// Core-side fetch/data handshakes and the unified single-port memory bus.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface rv32e_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Round-robin sharing of one single-port memory between RV32E fetch and data ports, one access in flight.
// Ack arrives LATENCY+1 edges after a request is sampled; requesters hold req until ack.
module rv32e_mem_arbiter #(
  parameter int LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  rv32e_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       rr_last;     // 1: data port won the most recent grant
  logic       gnt_d;
  logic       gnt_we;
  logic       any_req;
  logic       win_f;
  logic       grant_f;
  logic       grant_d;
  logic       issue_done;
  logic       xfer_done;

  assign any_req = bus.if_req | bus.d_req;
  assign win_f   = bus.if_req & (~bus.d_req | rr_last);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    issue_done = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      IDLE: begin
        grant_f = any_req & win_f;
        grant_d = bus.d_req & ~win_f;
      end
      ISSUE:   issue_done = 1'b1;
      WAIT:    xfer_done = (cnt == 2'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= 2'd0;
      rr_last       <= 1'b1;
      gnt_d         <= 1'b0;
      gnt_we        <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.if_rdata  <= 32'h0;
      bus.d_rdata   <= 32'h0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      if (grant_f) begin
        bus.mem_en   <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_be   <= 4'hf;
        bus.mem_addr <= bus.if_addr;
        gnt_d        <= 1'b0;
        gnt_we       <= 1'b0;
        rr_last      <= 1'b0;
      end else if (grant_d) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_be    <= bus.d_we ? bus.d_be : 4'hf;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        gnt_d         <= 1'b1;
        gnt_we        <= bus.d_we;
        rr_last       <= 1'b1;
      end
      if (issue_done) begin
        bus.mem_en <= 1'b0;
        bus.mem_we <= 1'b0;
        cnt        <= CNT_INIT;
      end
      if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      // Writes complete without touching d_rdata.
      if (xfer_done) begin
        if (gnt_d) begin
          bus.d_ack <= 1'b1;
          if (!gnt_we) bus.d_rdata <= bus.mem_rdata;
        end else begin
          bus.if_ack   <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Bench for rv32e_mem_arbiter: LATENCY=1 and LATENCY=3 instances against a grant-relative
// transaction model, plus literal expectations from the directed scenarios.
module tb_rv32e_mem_arbiter;
  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  rv32e_mem_arbiter_if b1();
  rv32e_mem_arbiter_if b3();

  rv32e_mem_arbiter #(.LATENCY(1)) u1 (.clk(clk), .reset(rst1), .bus(b1));
  rv32e_mem_arbiter #(.LATENCY(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));

  typedef struct packed {
    logic        rst, if_req, d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] if_addr, d_addr, d_wdata;
  } in_t;

  typedef struct packed {
    logic        if_ack, d_ack, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  } out_t;

  localparam int PH_RST = 0, PH_FETCH = 1, PH_WR = 2, PH_BE0 = 3, PH_RD = 4;
  localparam int PH_RR = 5, PH_MID = 6, PH_RST2 = 7, PH_LAT = 8, PH_END = 9;

  int ph = PH_RST;
  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'h00500093;
    if (a == 9) return 32'h00a00113;
    return 32'h0;
  endfunction

  function automatic in_t get_in(input int i);
    if (i == 0) return '{rst1, b1.if_req, b1.d_req, b1.d_we, b1.d_be, b1.if_addr, b1.d_addr, b1.d_wdata};
    return '{rst3, b3.if_req, b3.d_req, b3.d_we, b3.d_be, b3.if_addr, b3.d_addr, b3.d_wdata};
  endfunction

  function automatic out_t get_out(input int i);
    if (i == 0) return '{b1.if_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.mem_be,
                         b1.if_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata};
    return '{b3.if_ack, b3.d_ack, b3.mem_en, b3.mem_we, b3.mem_be,
             b3.if_rdata, b3.d_rdata, b3.mem_addr, b3.mem_wdata};
  endfunction

  // Memory environment: read data appears LATENCY cycles after the mem_en cycle.
  logic [31:0] emem [2][64];
  logic [31:0] pipe [2][4];
  assign b1.mem_rdata = pipe[0][0];
  assign b3.mem_rdata = pipe[1][2];

  always @(posedge clk) begin : env
    in_t  es;
    out_t eo;
    for (int i = 0; i < 2; i++) begin
      es = get_in(i);
      eo = get_out(i);
      if (es.rst) begin
        for (int a = 0; a < 64; a++) emem[i][a] <= init_word(a);
      end else if (eo.mem_en && eo.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (eo.mem_be[b]) emem[i][eo.mem_addr[5:0]][8*b +: 8] <= eo.mem_wdata[8*b +: 8];
      end
      pipe[i][0] <= (eo.mem_en && !eo.mem_we) ? emem[i][eo.mem_addr[5:0]] : 32'ha5a5a5a5;
      for (int j = 1; j < 4; j++) pipe[i][j] <= pipe[i][j-1];
    end
  end

  // Reference model: a grant at edge t0 completes at edge t0+LATENCY+1.
  bit          started [2];
  bit          busy    [2];
  bit          rr_d    [2];
  bit          g_d     [2];
  bit          g_we    [2];
  bit          ack_d   [2];
  int          t0      [2];
  int          ack_edge[2];
  logic [3:0]  g_be    [2];
  logic [31:0] g_addr  [2];
  logic [31:0] g_wdata [2];
  logic [31:0] g_val   [2];
  logic [31:0] x_if    [2];
  logic [31:0] x_d     [2];
  logic [31:0] refmem  [2][64];

  always @(posedge clk) begin : model
    in_t s;
    edge_n = edge_n + 1;
    for (int i = 0; i < 2; i++) begin
      s = get_in(i);
      if (s.rst) begin
        started[i] = 1'b1; busy[i] = 1'b0; rr_d[i] = 1'b1; ack_edge[i] = -1;
        g_we[i] = 1'b0; g_be[i] = 4'h0; g_addr[i] = 32'h0; x_if[i] = 32'h0; x_d[i] = 32'h0;
        for (int a = 0; a < 64; a++) refmem[i][a] = init_word(a);
      end else if (busy[i]) begin
        if (edge_n - t0[i] == lat(i) + 1) begin
          busy[i] = 1'b0; ack_edge[i] = edge_n; ack_d[i] = g_d[i];
          if (!g_we[i]) begin
            if (g_d[i]) x_d[i] = g_val[i];
            else        x_if[i] = g_val[i];
          end
        end
      end else if (s.if_req || s.d_req) begin
        g_d[i] = !(s.if_req && (!s.d_req || rr_d[i]));
        rr_d[i] = g_d[i]; busy[i] = 1'b1; t0[i] = edge_n;
        if (g_d[i]) begin
          g_we[i] = s.d_we; g_be[i] = s.d_we ? s.d_be : 4'hf;
          g_addr[i] = s.d_addr; g_wdata[i] = s.d_wdata;
        end else begin
          g_we[i] = 1'b0; g_be[i] = 4'hf; g_addr[i] = s.if_addr;
        end
        g_val[i] = refmem[i][g_addr[i][5:0]];
        if (g_we[i])
          for (int b = 0; b < 4; b++)
            if (g_be[i][b]) refmem[i][g_addr[i][5:0]][8*b +: 8] = g_wdata[i][8*b +: 8];
      end
    end
  end

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s at edge %0d: got %h expected %h", i, nm, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    out_t o;
    bit   en_x;
    int   rr_k;
    int   last_ack;
    bit   seen2;
    if (ph != PH_RR)   begin rr_k = 0; last_ack = -1; end
    if (ph != PH_RST2) seen2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (edge_n > 0 && started[i]) begin
        o = get_out(i);
        en_x = busy[i] && (edge_n == t0[i]);
        chk(i, "mem_en",   32'(o.mem_en), 32'(en_x));
        chk(i, "mem_we",   32'(o.mem_we), 32'(en_x && g_we[i]));
        chk(i, "mem_be",   32'(o.mem_be), 32'(g_be[i]));
        chk(i, "mem_addr", o.mem_addr, g_addr[i]);
        if (en_x && g_we[i]) chk(i, "mem_wdata", o.mem_wdata, g_wdata[i]);
        chk(i, "if_ack",   32'(o.if_ack), 32'(edge_n == ack_edge[i] && !ack_d[i]));
        chk(i, "d_ack",    32'(o.d_ack),  32'(edge_n == ack_edge[i] && ack_d[i]));
        chk(i, "if_rdata", o.if_rdata, x_if[i]);
        chk(i, "d_rdata",  o.d_rdata, x_d[i]);
        chk(i, "ack_excl", 32'(o.if_ack & o.d_ack), 32'h0);
        if (o.if_ack || o.d_ack) chk(i, "ack_latency", 32'(edge_n - t0[i]), (i == 0) ? 32'd2 : 32'd4);
        if (i == 0) begin
          if (ph == PH_FETCH && o.if_ack) chk(i, "fetch_word", o.if_rdata, 32'h00500093);
          if (ph == PH_WR && o.mem_en) begin
            chk(i, "wr_be", 32'(o.mem_be), 32'h3);
            chk(i, "wr_we", 32'(o.mem_we), 32'h1);
          end
          if (ph == PH_RD && o.d_ack) chk(i, "load_word", o.d_rdata, 32'h0000beef);
          if (ph == PH_RR && o.mem_en) begin
            chk(i, "rr_order", o.mem_addr, (rr_k % 2 == 0) ? 32'd5 : 32'd9);
            rr_k++;
          end
          if (ph == PH_RR && (o.if_ack || o.d_ack)) begin
            if (last_ack >= 0) chk(i, "ack_spacing", 32'(edge_n - last_ack), 32'd3);
            last_ack = edge_n;
          end
          if (ph == PH_RST2 && o.mem_en && !seen2) begin
            chk(i, "post_reset_first", o.mem_addr, 32'd5);
            seen2 = 1'b1;
          end
        end else if (ph == PH_LAT && o.if_ack) begin
          chk(i, "lat3_fetch_word", o.if_rdata, 32'h00500093);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = 32'h0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_be = 4'h0; b1.d_addr = 32'h0; b1.d_wdata = 32'h0;
    b3.if_req = 1'b0; b3.if_addr = 32'h0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_be = 4'h0; b3.d_addr = 32'h0; b3.d_wdata = 32'h0;
    step(2);
    rst1 = 1'b0; rst3 = 1'b0;
    step(2);

    ph = PH_FETCH;
    b1.if_req = 1'b1; b1.if_addr = 32'd5;
    step(3); b1.if_req = 1'b0; step(2);

    ph = PH_WR;
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'd8; b1.d_wdata = 32'hdeadbeef; b1.d_be = 4'b0011;
    step(3); b1.d_req = 1'b0; step(2);

    ph = PH_BE0;
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'd8; b1.d_wdata = 32'hffffffff; b1.d_be = 4'b0000;
    step(3); b1.d_req = 1'b0; step(2);

    ph = PH_RD;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd8; b1.d_be = 4'b0000;
    step(3); b1.d_req = 1'b0; step(2);

    ph = PH_RR;
    rst1 = 1'b1; step(2); rst1 = 1'b0;
    b1.if_req = 1'b1; b1.if_addr = 32'd5; b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd9;
    step(12); b1.if_req = 1'b0; b1.d_req = 1'b0; step(2);

    ph = PH_MID;
    b1.if_req = 1'b1; b1.if_addr = 32'd5;
    step(2); rst1 = 1'b1; b1.if_req = 1'b0;
    step(1); rst1 = 1'b0;
    step(2);

    ph = PH_RST2;
    b1.if_req = 1'b1; b1.if_addr = 32'd5; b1.d_req = 1'b1; b1.d_addr = 32'd9;
    step(3); b1.if_req = 1'b0; b1.d_req = 1'b0; step(2);

    ph = PH_LAT;
    b3.if_req = 1'b1; b3.if_addr = 32'd5; b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'd9;
    step(2); b3.if_addr = 32'd7;
    step(3); b3.if_req = 1'b0;
    step(2); b3.d_addr = 32'd6;
    step(3); b3.d_req = 1'b0;
    step(3);

    ph = PH_END;
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32e_mem_arbiter.md
# rv32e_mem_arbiter

Shares one single-port synchronous memory between the RV32E core's instruction-fetch port and its data load/store port. Each port uses a simple req/ack handshake. Simultaneous requests are resolved round-robin. Exactly one memory access is outstanding at a time, sequenced by a small FSM. The block sits between the core's program/data buses and the unified memory.

## Interface

Parameters:
- `LATENCY`, default 1: memory read latency in cycles, counted from the cycle `mem_en` is high to the cycle `mem_rdata` is valid; legal range 1–4.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  32  fetch word address
- `if_rdata`  out  32  fetched instruction, valid while `if_ack` is high, held afterwards
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_be`  in  4  byte enables for writes
- `d_addr`  in  32  data word address
- `d_wdata`  in  32  write data
- `d_rdata`  out  32  load data, valid while `d_ack` is high, held afterwards
- `d_ack`  out  1  one-cycle completion pulse
- `mem_en`  out  1  memory access strobe, registered
- `mem_we`  out  1  memory write, registered; 0 whenever `mem_en` is 0
- `mem_be`  out  4  memory byte enables, registered; `4'b1111` for reads
- `mem_addr`  out  32  memory word address, registered
- `mem_wdata`  out  32  memory write data, registered
- `mem_rdata`  in  32  memory read data

## Operation

- FSM states: IDLE, ISSUE, WAIT. A last-grant flag `rr_last` selects between fetch (F) and data (D).
- **IDLE**
  - If `if_req` or `d_req` is sampled high, grant one requester.
  - Latch its address, `we`, `be` and `wdata` into the `mem_*` registers, set `mem_en`=1, and go to ISSUE.
  - Fetch grants always drive `mem_we`=0 and `mem_be`=`4'b1111`.
- **Arbitration**
  - A single requester wins immediately.
  - When both request, the requester not equal to `rr_last` wins.
  - `rr_last` updates to the winner at the grant edge.
- **ISSUE** (one cycle, `mem_en` high)
  - At the next edge: `mem_en`<=0, `mem_we`<=0, counter <= `LATENCY`-1, go to WAIT.
- **WAIT**
  - If counter != 0: decrement.
  - If counter == 0, for a read grant: capture `mem_rdata` into the granted port's `rdata`, then pulse that port's `ack` for one cycle and go to IDLE.
  - If counter == 0, for a write grant: leave `d_rdata` unchanged, then pulse `d_ack` for one cycle and go to IDLE.
- **Input sampling**
  - Request inputs are sampled only in IDLE.
  - Changes to `addr`, `wdata`, `we`, `be` or `req` during ISSUE or WAIT are ignored.
  - A request dropped before its ack still completes and still acks.
- **Back-to-back requests**
  - A `req` still high in the cycle its `ack` is high is treated as a new request and is sampled at the next edge (IDLE).
  - Requesters wanting only one access must drop `req` in the ack cycle.
- **Writes**
  - A write with `d_be`=0 is still issued (no lanes are written) and acked.
- **Reset**, including mid-transaction:
  - State returns to IDLE and the counter clears.
  - `mem_en`, `mem_we`, `if_ack` and `d_ack` go to 0.
  - `mem_be`, `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata` go to 0.
  - `rr_last` is set to D, so fetch wins the first conflict.
  - An aborted transaction never acks.

## Timing

- Request sampled at edge E0 → `mem_en` high in the cycle after E0 → memory samples at E1.
- Capture happens at edge E(1+`LATENCY`); `ack` is high in the cycle after it.
- Request-to-ack is `LATENCY`+1 edges; `LATENCY`=1 gives ack 2 cycles after the sampling edge.
- Throughput is one access per `LATENCY`+2 cycles.
- `if_ack` and `d_ack` are never high in the same cycle.
- `mem_en` is high for exactly one cycle per grant.
- Under continuous dual requests, grants alternate F, D, F, D…; neither port waits more than one foreign transaction.

## Test plan

- **Reset and idle.** Assert `reset` for 2 cycles with no requests. All outputs must be 0, `mem_en` must stay 0, and there must be no acks.
- **Single fetch, `LATENCY`=1.** `if_req`=1, `if_addr`=5, memory returns `32'h00500093` for address 5. Expect `mem_en` for 1 cycle with `mem_addr`=5 and `mem_we`=0. `if_ack` is high 2 cycles after the sampling edge, with `if_rdata`=`32'h00500093`.
- **Data write then read.** Write `d_addr`=8, `d_wdata`=`32'hDEADBEEF`, `d_be`=`4'b0011`: expect `mem_we`=1 and `mem_be`=`4'b0011`, `d_ack` pulses, and `d_rdata` stays unchanged. A following read of address 8 must return the modelled `32'h0000BEEF`.
- **Conflict round-robin.** Hold both `req` high continuously after reset. Grant order must be F, D, F, D. Each ack is a one-cycle pulse, with acks spaced `LATENCY`+2 cycles apart.
- **Latency sweep.** With `LATENCY`=3, a fetch must ack 4 cycles after the sampling edge, and `mem_addr`/`if_addr` changes during WAIT must have no effect.
- **Reset mid-transaction.** Assert `reset` during WAIT. There must be no ack, `mem_en`=0, and state must be IDLE. The next conflicting request must grant fetch first.
